// File: rtl/i2s_rx_sample.sv
// ---------------------------------------------------------------------------
// i2s_rx_sample
//   I2S slave receiver and sample formatter feeding a 12-bit PWM DAC.
//   BCLK/LRCK/SDATA are oversampled on pwm_clk (>= 4x BCLK). Each input goes
//   through a 2-FF synchronizer, and all I2S logic acts only on a detected BCLK
//   rise. The selected channel (left, right or mono mix) is converted from
//   signed two's complement to an unsigned offset-binary duty word.
//
// Ports
//   pwm_clk       in   1          only clock
//   Reset_n       in   1          asynchronous, active-low reset
//   i2s_bclk      in   1          I2S bit clock (asynchronous to pwm_clk)
//   i2s_lrck      in   1          I2S word select, 0 = left, 1 = right
//   i2s_sdata     in   1          I2S serial data, MSB first, one-bit delayed
//   din_out       out  OUT_WIDTH  unsigned duty word for the DAC
//   sample_valid  out  1          one-cycle pulse when din_out takes a new value
//   frame_err     out  1          one-cycle pulse when a word is cut short
//   o_dbg_state   out  2          receiver FSM state (IDLE/SKIP/SHIFT/DONE)
//
// Output handshake: sample_valid is a plain valid qualifier with no ready.
// It is high for exactly one pwm_clk cycle, in the same cycle din_out first
// shows the new word; the sink must accept every pulse. din_out holds its
// value between pulses.
// ---------------------------------------------------------------------------
module i2s_rx_sample #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_WIDTH    = 12,
    parameter int CHANNEL_SEL  = 0
) (
    input  logic                 pwm_clk,
    input  logic                 Reset_n,
    input  logic                 i2s_bclk,
    input  logic                 i2s_lrck,
    input  logic                 i2s_sdata,
    output logic [OUT_WIDTH-1:0] din_out,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic [1:0]           o_dbg_state
);

    localparam int                   CW       = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0]        LAST_CNT = CW'(SAMPLE_WIDTH);
    localparam logic [OUT_WIDTH-1:0] MIDSCALE = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Synchronizers: index 0 = sync1, 1 = sync2, 2 = sync3 (BCLK only).
    logic [2:0]              r_bclk_sync;
    logic [1:0]              r_lrck_sync;
    logic [1:0]              r_sdata_sync;

    state_t                  r_state;
    logic                    r_primed;   // lrck_q holds a real sample
    logic                    r_lrck_q;
    logic                    r_ch_id;
    logic [CW-1:0]           r_cnt;
    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic                    r_upd;
    logic                    r_frame_err;
    logic                    r_valid;
    logic [OUT_WIDTH-1:0]    r_din;

    logic                    w_rise;
    logic                    w_lrck_s;
    logic                    w_sdata_s;
    logic                    w_lr_change;
    logic                    w_trigger;
    logic [CW-1:0]           w_cnt_next;
    logic [SAMPLE_WIDTH-1:0] w_shift_next;
    logic [SAMPLE_WIDTH:0]   w_mix_sum;
    logic [SAMPLE_WIDTH-1:0] w_mix;
    logic [SAMPLE_WIDTH-1:0] w_sel;
    logic [OUT_WIDTH-1:0]    w_fmt;
    logic                    w_unused;

    assign w_rise       = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_lrck_s     = r_lrck_sync[1];
    assign w_sdata_s    = r_sdata_sync[1];
    // The first rise after reset only loads lrck_q, so a stale reset value
    // of lrck_q can never fake a word boundary in the middle of a slot.
    assign w_lr_change  = r_primed & (w_lrck_s != r_lrck_q);
    assign w_cnt_next   = r_cnt + 1'b1;
    assign w_shift_next = {r_shift, w_sdata_s};
    assign w_trigger    = (CHANNEL_SEL == 0) ? ~r_ch_id : r_ch_id;

    // Mono: sign-extend both words by one bit, add, drop the LSB (>>> 1).
    assign w_mix_sum = {r_left[SAMPLE_WIDTH-1], r_left} + {r_right[SAMPLE_WIDTH-1], r_right};
    assign w_mix     = w_mix_sum[SAMPLE_WIDTH:1];
    assign w_sel     = (CHANNEL_SEL == 0) ? r_left :
                       (CHANNEL_SEL == 1) ? r_right : w_mix;
    // Top OUT_WIDTH bits, truncated; flipping the sign bit gives offset binary.
    assign w_fmt     = w_sel[SAMPLE_WIDTH-1 -: OUT_WIDTH] ^ MIDSCALE;
    assign w_unused  = ^{w_mix_sum[0], w_sel};

    always_ff @(posedge pwm_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_bclk_sync  <= '0;
            r_lrck_sync  <= '0;
            r_sdata_sync <= '0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[1:0], i2s_bclk};
            r_lrck_sync  <= {r_lrck_sync[0], i2s_lrck};
            r_sdata_sync <= {r_sdata_sync[0], i2s_sdata};
        end
    end

    // Receiver FSM. The rise on which LRCK changes carries the previous word's
    // LSB (I2S one-bit delay), so SKIP is entered on that rise and the next
    // rise already shifts the new word's MSB.
    always_ff @(posedge pwm_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_primed    <= 1'b0;
            r_lrck_q    <= 1'b0;
            r_ch_id     <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_upd       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_upd       <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_rise) begin
                r_lrck_q <= w_lrck_s;
                r_primed <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (w_lr_change) begin
                            r_ch_id <= w_lrck_s;
                            r_cnt   <= '0;
                            r_state <= S_SKIP;
                        end
                    end
                    S_SKIP, S_SHIFT: begin
                        r_shift <= w_shift_next[SAMPLE_WIDTH-2:0];
                        if (w_cnt_next == LAST_CNT) begin
                            // Word complete; a coincident LRCK edge still
                            // counts as complete and starts the next word.
                            if (r_ch_id) begin
                                r_right <= w_shift_next;
                            end else begin
                                r_left  <= w_shift_next;
                            end
                            r_upd <= w_trigger;
                            if (w_lr_change) begin
                                r_ch_id <= w_lrck_s;
                                r_cnt   <= '0;
                                r_state <= S_SKIP;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else if (w_lr_change) begin
                            // Truncated word: discard it and resync.
                            r_frame_err <= 1'b1;
                            r_ch_id     <= w_lrck_s;
                            r_cnt       <= '0;
                            r_state     <= S_SKIP;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_state <= S_SHIFT;
                        end
                    end
                    S_DONE: begin
                        if (w_lr_change) begin
                            r_ch_id <= w_lrck_s;
                            r_cnt   <= '0;
                            r_state <= S_SKIP;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Output stage: one cycle after the channel register latches.
    always_ff @(posedge pwm_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_din   <= MIDSCALE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_upd;
            if (r_upd) begin
                r_din <= w_fmt;
            end
        end
    end

    assign din_out      = r_din;
    assign sample_valid = r_valid;
    assign frame_err    = r_frame_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_i2s_rx_sample.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_sample
//   Drives one I2S stream into three receivers (left, right, mono) and checks
//   every sample_valid pulse (cycle and value), frame_err counts and held
//   din_out values against a reference model built from the I2S slot layout.
// ---------------------------------------------------------------------------
module tb_i2s_rx_sample;

    localparam int SW = 16;
    localparam int OW = 12;

    // ---------------- clock / reset ----------------
    logic pwm_clk   = 1'b0;
    logic Reset_n   = 1'b0;
    logic i2s_bclk  = 1'b0;
    logic i2s_lrck  = 1'b0;
    logic i2s_sdata = 1'b0;

    always #5 pwm_clk = ~pwm_clk;

    int cyc = 0;
    always @(posedge pwm_clk) cyc <= cyc + 1;

    logic [OW-1:0] din0, din1, din2;
    logic          sv0, sv1, sv2;
    logic          fe0, fe1, fe2;
    logic [1:0]    st_unused0, st_unused1, st_unused2;

    i2s_rx_sample #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .CHANNEL_SEL(0)) u_left (
        .pwm_clk(pwm_clk), .Reset_n(Reset_n), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
        .i2s_sdata(i2s_sdata), .din_out(din0), .sample_valid(sv0), .frame_err(fe0),
        .o_dbg_state(st_unused0));
    i2s_rx_sample #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .CHANNEL_SEL(1)) u_right (
        .pwm_clk(pwm_clk), .Reset_n(Reset_n), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
        .i2s_sdata(i2s_sdata), .din_out(din1), .sample_valid(sv1), .frame_err(fe1),
        .o_dbg_state(st_unused1));
    i2s_rx_sample #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .CHANNEL_SEL(2)) u_mono (
        .pwm_clk(pwm_clk), .Reset_n(Reset_n), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
        .i2s_sdata(i2s_sdata), .din_out(din2), .sample_valid(sv2), .frame_err(fe2),
        .o_dbg_state(st_unused2));

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]    inst;
        logic [31:0]   t;
        logic [OW-1:0] v;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  fe_obs0 = 0, fe_obs1 = 0, fe_obs2 = 0;
    int  exp_fe = 0;
    logic [OW-1:0] cur [3];

    function automatic ev_t mk_ev(input int inst, input int t, input logic [OW-1:0] v);
        ev_t e;
        e.inst = 2'(inst);
        e.t    = 32'(t);
        e.v    = v;
        return e;
    endfunction

    always @(negedge pwm_clk) begin
        if (sv0 === 1'b1) obs_q.push_back(mk_ev(0, cyc, din0));
        if (sv1 === 1'b1) obs_q.push_back(mk_ev(1, cyc, din1));
        if (sv2 === 1'b1) obs_q.push_back(mk_ev(2, cyc, din2));
        if (fe0 === 1'b1) fe_obs0 <= fe_obs0 + 1;
        if (fe1 === 1'b1) fe_obs1 <= fe_obs1 + 1;
        if (fe2 === 1'b1) fe_obs2 <= fe_obs2 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Stream position p: q_lr[p] is LRCK, q_sd[p] is SDATA for the p-th BCLK
    // period. SDATA is the slot data delayed by one BCLK (I2S format).
    logic        q_lr[$];
    logic        q_sd[$];
    int          mk_ch[int];   // position of a complete word's last bit -> channel
    logic [SW-1:0] mk_w[int];  // ... -> word
    int          mk_ss[int];   // ... -> slot start
    int          fe_ss[int];   // position of an early LRCK edge -> slot start
    int          play_pos  = 0;
    int          reset_pos = 0;
    logic [SW-1:0] last_left = '0;

    function automatic int sval(input logic [SW-1:0] w);
        return int'($signed(w));
    endfunction

    // Offset binary: add half scale, keep the top OW bits.
    function automatic logic [OW-1:0] to_duty(input int s);
        int u;
        u = s + (1 << (SW - 1));
        return OW'(u >> (SW - OW));
    endfunction

    task automatic push_exp(input int i, input int t, input logic [OW-1:0] v);
        exp_q.push_back(mk_ev(i, t, v));
        cur[i] = v;
    endtask

    task automatic add_slot(input logic lr, input logic [SW-1:0] w, input int nbits);
        int ss;
        ss = q_lr.size();
        for (int k = 0; k < nbits; k++) begin
            q_lr.push_back(lr);
            if (k < SW) q_sd.push_back(w[SW-1-k]);
            else        q_sd.push_back(1'($urandom_range(0, 1)));
        end
        if (nbits >= SW) begin
            mk_ch[ss + SW] = int'(lr);
            mk_w[ss + SW]  = w;
            mk_ss[ss + SW] = ss;
        end else begin
            fe_ss[ss + nbits] = ss;
        end
    endtask

    task automatic add_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                             input int nl, input int nr);
        add_slot(1'b0, l, nl);
        add_slot(1'b1, r, nr);
    endtask

    // A slot is captured only if it starts after the first post-reset rise.
    task automatic model_at(input int p, input int t);
        if (mk_ch.exists(p)) begin
            if (mk_ss[p] > reset_pos) begin
                if (mk_ch[p] == 0) begin
                    last_left = mk_w[p];
                    push_exp(0, t, to_duty(sval(mk_w[p])));
                end else begin
                    push_exp(1, t, to_duty(sval(mk_w[p])));
                    push_exp(2, t, to_duty((sval(last_left) + sval(mk_w[p])) >>> 1));
                end
            end
        end
        if (fe_ss.exists(p)) begin
            if (fe_ss[p] > reset_pos) exp_fe++;
        end
    endtask

    // ---------------- driver ----------------
    // BCLK = pwm_clk/4: low for two edges, high for two edges. The pwm_clk
    // edge after raising BCLK is where sync1 first sees it (edge N); the
    // update is due at N+3, i.e. four edges after the raise.
    task automatic play(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge pwm_clk); #1;
            i2s_bclk  = 1'b0;
            i2s_lrck  = q_lr[play_pos];
            i2s_sdata = q_sd[play_pos];
            @(posedge pwm_clk);
            @(posedge pwm_clk); #1;
            i2s_bclk = 1'b1;
            model_at(play_pos, cyc + 4);
            @(posedge pwm_clk);
            play_pos++;
        end
    endtask

    task automatic play_all();
        play(q_lr.size() - play_pos);
    endtask

    task automatic check_step(input string tag);
        ev_t o, e;
        repeat (10) @(posedge pwm_clk);
        #1;
        chk({tag, " pulse_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " pulse{inst,cycle,din}"}, 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, " frame_err_L"}, 64'(fe_obs0), 64'(exp_fe));
        chk({tag, " frame_err_R"}, 64'(fe_obs1), 64'(exp_fe));
        chk({tag, " frame_err_M"}, 64'(fe_obs2), 64'(exp_fe));
        chk({tag, " din_L"}, 64'(din0), 64'(cur[0]));
        chk({tag, " din_R"}, 64'(din1), 64'(cur[1]));
        chk({tag, " din_M"}, 64'(din2), 64'(cur[2]));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " din_L"}, 64'(din0), 64'h800);
        chk({tag, " din_R"}, 64'(din1), 64'h800);
        chk({tag, " din_M"}, 64'(din2), 64'h800);
        chk({tag, " valid"}, 64'({sv0, sv1, sv2}), 64'h0);
        chk({tag, " frame_err"}, 64'({fe0, fe1, fe2}), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 3; i++) cur[i] = 12'h800;
        q_sd.push_back(1'b0);

        // Reset with no BCLK, then hold idle.
        repeat (5) @(posedge pwm_clk);
        #1;
        check_reset_vals("reset");
        @(negedge pwm_clk);
        Reset_n = 1'b1;
        repeat (1000) @(posedge pwm_clk);
        #1;
        check_reset_vals("idle_1000");
        check_step("idle");

        // Left channel values, 16-bit slots. First slot only primes LRCK.
        add_slot(1'b1, 16'h0000, 16);
        add_frame(16'h7FFF, 16'h1111, 16, 16);
        add_frame(16'h8000, 16'h2222, 16, 16);
        add_frame(16'h0000, 16'h3333, 16, 16);
        add_frame(16'h1234, 16'h4444, 16, 16);
        play_all();
        check_step("left_words");
        chk("left_0x1234", 64'(din0), 64'h923);

        // Mono mix.
        add_frame(16'h4000, 16'hC000, 16, 16);
        add_slot(1'b0, 16'h7FFF, 16);
        play_all();
        check_step("mono_cancel");
        chk("mono_4000_C000", 64'(din2), 64'h800);

        // Right 0x7FFF, then a left word in a 32-bit slot with junk.
        add_slot(1'b1, 16'h7FFF, 16);
        add_slot(1'b0, 16'hA5A5, 32);
        play_all();
        check_step("mono_max_slot32");
        chk("mono_7FFF_7FFF", 64'(din2), 64'hFFF);
        chk("left_slot32_A5A5", 64'(din0), 64'h25A);

        // Truncated left word (10 bits).
        add_slot(1'b1, 16'h5A5A, 32);
        add_slot(1'b0, 16'hFFFF, 10);
        add_slot(1'b1, 16'h0101, 16);
        play_all();
        check_step("truncated");
        chk("trunc_din_held", 64'(din0), 64'h25A);
        add_slot(1'b0, 16'h0F0F, 16);
        add_slot(1'b1, 16'h0202, 16);
        play_all();
        check_step("after_trunc");
        chk("after_trunc_0F0F", 64'(din0), 64'h8F0);

        // Reset in the middle of a left word.
        add_slot(1'b0, 16'h7FFF, 16);
        play(8);
        check_step("pre_reset");
        Reset_n = 1'b0;
        #1;
        chk("midreset_din_L", 64'(din0), 64'h800);
        chk("midreset_din_R", 64'(din1), 64'h800);
        chk("midreset_din_M", 64'(din2), 64'h800);
        for (int i = 0; i < 3; i++) cur[i] = 12'h800;
        last_left = '0;
        reset_pos = play_pos;
        repeat (5) @(posedge pwm_clk);
        @(negedge pwm_clk);
        Reset_n = 1'b1;
        add_slot(1'b1, 16'h4444, 16);
        add_slot(1'b0, 16'h6666, 16);
        add_slot(1'b1, 16'h0303, 16);
        play_all();
        check_step("post_reset");
        chk("post_reset_right", 64'(din1), 64'hC44);
        chk("post_reset_left", 64'(din0), 64'hE66);

        // Random frames: random words, slot lengths, occasional truncation.
        for (int f = 0; f < 30; f++) begin
            int nl, nr;
            nl = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 15) : $urandom_range(16, 32);
            nr = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 15) : $urandom_range(16, 32);
            add_frame(16'($urandom), 16'($urandom), nl, nr);
        end
        play_all();
        check_step("random");

        add_slot(1'b0, 16'($urandom), 16);
        play_all();
        check_step("flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
